instr_encoder: RTL and testbench



---
 rtl/mips_isa_pkg.sv | 45 ++++
 rtl/instr_fmt.sv | 60 ++++++
 rtl/instr_encoder.sv | 123 ++++++++++++
 tb/tb_instr_encoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes (same values Control decodes), the jr
// funct code, the loader command kinds and a small I-format packing helper.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [3:0] {
        KIND_R     = 4'd0,
        KIND_JR    = 4'd1,
        KIND_J     = 4'd2,
        KIND_JAL   = 4'd3,
        KIND_BEQ   = 4'd4,
        KIND_BNE   = 4'd5,
        KIND_ADDI  = 4'd6,
        KIND_ADDIU = 4'd7,
        KIND_ANDI  = 4'd8,
        KIND_ORI   = 4'd9,
        KIND_XORI  = 4'd10,
        KIND_LUI   = 4'd11,
        KIND_LW    = 4'd12,
        KIND_SW    = 4'd13,
        KIND_LI    = 4'd14,
        KIND_RSVD  = 4'd15
    } cmd_kind_e;

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_fmt.sv
// Combinational command formatter: builds the first (and, for a split LI,
// the second) instruction word and flags reserved command kinds.
module instr_fmt
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [31:0] imm,
    output logic [31:0] word0,
    output logic [31:0] word1,
    output logic        two_words,
    output logic        illegal
);

    logic [15:0] imm_hi;
    logic [15:0] imm_lo;

    assign imm_hi = imm[31:16];
    assign imm_lo = imm[15:0];

    always_comb begin
        word0     = '0;
        word1     = '0;
        two_words = 1'b0;
        illegal   = 1'b0;
        case (kind)
            KIND_R:     word0 = {OP_RTYPE, rs, rt, rd, imm[4:0], funct};
            KIND_JR:    word0 = {OP_RTYPE, rs, 15'd0, FUNCT_JR};
            KIND_J:     word0 = {OP_J, imm[25:0]};
            KIND_JAL:   word0 = {OP_JAL, imm[25:0]};
            KIND_BEQ:   word0 = i_word(OP_BEQ, rs, rt, imm_lo);
            KIND_BNE:   word0 = i_word(OP_BNE, rs, rt, imm_lo);
            KIND_ADDI:  word0 = i_word(OP_ADDI, rs, rt, imm_lo);
            KIND_ADDIU: word0 = i_word(OP_ADDIU, rs, rt, imm_lo);
            KIND_ANDI:  word0 = i_word(OP_ANDI, rs, rt, imm_lo);
            KIND_ORI:   word0 = i_word(OP_ORI, rs, rt, imm_lo);
            KIND_XORI:  word0 = i_word(OP_XORI, rs, rt, imm_lo);
            KIND_LUI:   word0 = i_word(OP_LUI, 5'd0, rt, imm_lo);
            KIND_LW:    word0 = i_word(OP_LW, rs, rt, imm_lo);
            KIND_SW:    word0 = i_word(OP_SW, rs, rt, imm_lo);
            KIND_LI: begin
                // Pick the shortest expansion; only a value with both halves non-zero needs two words.
                if (imm_hi == 16'd0) begin
                    word0 = i_word(OP_ORI, 5'd0, rt, imm_lo);
                end else if (imm_lo == 16'd0) begin
                    word0 = i_word(OP_LUI, 5'd0, rt, imm_hi);
                end else begin
                    word0     = i_word(OP_LUI, 5'd0, rt, imm_hi);
                    word1     = i_word(OP_ORI, rt, rt, imm_lo);
                    two_words = 1'b1;
                end
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Loader-side instruction encoder: accepts commands, emits one or two encoded
// words per command on a valid/ready stream tagged with sequential imem addresses.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [5:0]        cmd_funct,
    input  logic [31:0]       cmd_imm,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  words_out,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_e;

    state_e              state_reg;
    logic                out_valid_reg;
    logic [31:0]         out_word_reg;
    logic [31:0]         word1_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [CNT_W-1:0]    words_reg;
    logic                err_reg;

    logic [31:0] fmt_word0;
    logic [31:0] fmt_word1;
    logic        fmt_two;
    logic        fmt_illegal;
    logic        accept;
    logic        handshake;

    instr_fmt u_fmt (
        .kind      (cmd_kind),
        .rs        (cmd_rs),
        .rt        (cmd_rt),
        .rd        (cmd_rd),
        .funct     (cmd_funct),
        .imm       (cmd_imm),
        .word0     (fmt_word0),
        .word1     (fmt_word1),
        .two_words (fmt_two),
        .illegal   (fmt_illegal)
    );

    // A new command may overlap the final handshake of the current one.
    assign cmd_ready = !load_en && (state_reg == IDLE || (state_reg == EMIT && out_ready));
    assign accept    = cmd_valid && cmd_ready;
    assign handshake = out_valid_reg && out_ready;

    assign out_valid = out_valid_reg;
    assign out_word  = out_word_reg;
    assign out_addr  = addr_reg;
    assign words_out = words_reg;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
            word1_reg     <= '0;
            addr_reg      <= '0;
            words_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (handshake) begin
                addr_reg <= addr_reg + 1'b1;
                if (words_reg != '1) begin
                    words_reg <= words_reg + 1'b1;
                end
            end
            if (accept && fmt_illegal) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        addr_reg <= load_addr;
                    end else if (accept && !fmt_illegal) begin
                        out_word_reg  <= fmt_word0;
                        word1_reg     <= fmt_word1;
                        out_valid_reg <= 1'b1;
                        state_reg     <= fmt_two ? EMIT2 : EMIT;
                    end
                end
                EMIT2: begin
                    if (handshake) begin
                        out_word_reg <= word1_reg;
                        state_reg    <= EMIT;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (accept && !fmt_illegal) begin
                            out_word_reg <= fmt_word0;
                            word1_reg    <= fmt_word1;
                            state_reg    <= fmt_two ? EMIT2 : EMIT;
                        end else begin
                            out_valid_reg <= 1'b0;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: every accepted word is logged
// by a stream monitor and compared against hand-encoded MIPS words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_kind;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [5:0]  cmd_funct;
    logic [31:0] cmd_imm;
    logic        load_en;
    logic [7:0]  load_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
    logic [15:0] words_out;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int valid_seen = 0;
    logic [31:0] q_word[$];
    logic [7:0]  q_addr[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .cmd_rd    (cmd_rd),
        .cmd_funct (cmd_funct),
        .cmd_imm   (cmd_imm),
        .load_en   (load_en),
        .load_addr (load_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .words_out (words_out),
        .err       (err)
    );

    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            q_word.push_back(out_word);
            q_addr.push_back(out_addr);
            q_cyc.push_back(cyc);
            $display("word addr=%02h data=%08h cycle=%0d", out_addr, out_word, cyc);
        end
        if (out_valid) valid_seen++;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the command is accepted.
    task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [31:0] imm);
        int waited;
        waited = 0;
        cmd_kind  = kind;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_rd    = rd;
        cmd_funct = funct;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q_word.delete();
        q_addr.delete();
        q_cyc.delete();
        valid_seen = 0;
    endtask

    task automatic check_stream(input string tag, input logic [31:0] exp_w[4],
                                input logic [7:0] exp_a[4], input int n);
        check({tag, "_count"}, 32'(q_word.size()), 32'(n));
        for (int i = 0; i < n && i < q_word.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), q_word[i], exp_w[i]);
            check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(exp_a[i]));
        end
    endtask

    logic [31:0] ew[4];
    logic [7:0]  ea[4];

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_kind = 4'd0; cmd_rs = 5'd0; cmd_rt = 5'd0;
        cmd_rd = 5'd0; cmd_funct = 6'd0; cmd_imm = 32'd0; load_en = 1'b0; load_addr = 8'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_words_out", 32'(words_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // ADDI $8,$9,5
        send(4'd6, 5'd9, 5'd8, 5'd0, 6'd0, 32'h0000_0005);
        wait_idle();
        ew = '{32'h21280005, 0, 0, 0}; ea = '{8'h00, 0, 0, 0};
        check_stream("addi", ew, ea, 1);
        check("addi_words_out", 32'(words_out), 32'd1);

        // R add, JR $31, JAL back-to-back
        do_reset();
        send(4'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 32'd0);
        send(4'd1, 5'd31, 5'd0, 5'd0, 6'd0, 32'd0);
        send(4'd3, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0010_0000);
        wait_idle();
        ew = '{32'h00221820, 32'h03E00008, 32'h0C100000, 0}; ea = '{8'h00, 8'h01, 8'h02, 0};
        check_stream("b2b", ew, ea, 3);
        if (q_cyc.size() == 3) begin
            check("b2b_gap01", 32'(q_cyc[1] - q_cyc[0]), 32'd1);
            check("b2b_gap12", 32'(q_cyc[2] - q_cyc[1]), 32'd1);
        end
        check("b2b_words_out", 32'(words_out), 32'd3);

        // LI expansions
        do_reset();
        send(4'd14, 5'd0, 5'd4, 5'd0, 6'd0, 32'h1234_5678);
        #1;
        check("li_ready_low_emit2", 32'(cmd_ready), 32'd0);
        send(4'd14, 5'd0, 5'd4, 5'd0, 6'd0, 32'h0000_ABCD);
        send(4'd14, 5'd0, 5'd4, 5'd0, 6'd0, 32'h0001_0000);
        wait_idle();
        ew = '{32'h3C041234, 32'h34845678, 32'h3404ABCD, 32'h3C040001};
        ea = '{8'h00, 8'h01, 8'h02, 8'h03};
        check_stream("li", ew, ea, 4);
        check("li_words_out", 32'(words_out), 32'd4);

        // Backpressure during a split LI
        do_reset();
        send(4'd14, 5'd0, 5'd4, 5'd0, 6'd0, 32'h1234_5678);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_word%0d", i), out_word, 32'h3C041234);
            check($sformatf("hold_addr%0d", i), 32'(out_addr), 32'd0);
            check($sformatf("hold_ready%0d", i), 32'(cmd_ready), 32'd0);
            check($sformatf("hold_valid%0d", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        wait_idle();
        ew = '{32'h3C041234, 32'h34845678, 0, 0}; ea = '{8'h00, 8'h01, 0, 0};
        check_stream("hold", ew, ea, 2);
        check("hold_words_out", 32'(words_out), 32'd2);

        // Base address load and wrap
        do_reset();
        load_en = 1'b1;
        load_addr = 8'hFE;
        cmd_valid = 1'b1;
        #1;
        check("load_blocks_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        load_en = 1'b0;
        cmd_valid = 1'b0;
        send(4'd6, 5'd9, 5'd8, 5'd0, 6'd0, 32'h0000_0001);
        send(4'd6, 5'd9, 5'd8, 5'd0, 6'd0, 32'h0000_0002);
        send(4'd6, 5'd9, 5'd8, 5'd0, 6'd0, 32'h0000_0003);
        wait_idle();
        ew = '{32'h21280001, 32'h21280002, 32'h21280003, 0}; ea = '{8'hFE, 8'hFF, 8'h00, 0};
        check_stream("wrap", ew, ea, 3);

        // Illegal kind and sticky err
        do_reset();
        send(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("illegal_no_valid", 32'(valid_seen), 32'd0);
        check("illegal_err", 32'(err), 32'd1);
        send(4'd6, 5'd9, 5'd8, 5'd0, 6'd0, 32'h0000_0005);
        wait_idle();
        check("err_sticky", 32'(err), 32'd1);
        check("illegal_then_addi_count", 32'(q_word.size()), 32'd1);

        // Reset while the ori half of an LI is pending
        q_word.delete(); q_addr.delete(); q_cyc.delete();
        out_ready = 1'b0;
        send(4'd14, 5'd0, 5'd4, 5'd0, 6'd0, 32'h1234_5678);
        check("emit2_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_out_word", out_word, 32'd0);
        check("rst2_out_addr", 32'(out_addr), 32'd0);
        check("rst2_words_out", 32'(words_out), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst2_no_ori", 32'(q_word.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
